ex_mem: RTL

EX_MEM -- requirements
Module: ex_mem

---
 rtl/ex_mem_pkg.sv | 19 +
 rtl/ex_mem_if.sv | 13 +
 rtl/ex_mem.sv | 46 ++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared bus widths, stall-bit indices, stop constants and the MEM entry type
package ex_mem_pkg;
  localparam int RegBusW  = 32;
  localparam int RegAddrW = 5;
  typedef logic [RegBusW-1:0]  reg_bus_t;
  typedef logic [RegAddrW-1:0] reg_addr_t;
  localparam reg_bus_t ZeroWord = '0;
  localparam int StallEx  = 3;
  localparam int StallMem = 4;
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;
  typedef struct packed {
    reg_addr_t waddr;
    logic      we;
    reg_bus_t  wdata;
    logic      valid;
  } mem_entry_t;
  localparam mem_entry_t Bubble = '{waddr: '0, we: 1'b0, wdata: ZeroWord, valid: 1'b0};
endpackage

// File: rtl/ex_mem_if.sv
// ex_mem_if: EX result bus into the EX/MEM register and the registered MEM bus out of it
interface ex_mem_if;
  import ex_mem_pkg::*;
  reg_addr_t ex_waddr_reg;
  logic      ex_we_reg;
  reg_bus_t  ex_wdata;
  reg_addr_t mem_waddr_reg;
  logic      mem_we_reg;
  reg_bus_t  mem_wdata;
  logic      mem_valid_o;
  modport master (output ex_waddr_reg, ex_we_reg, ex_wdata, input mem_waddr_reg, mem_we_reg, mem_wdata, mem_valid_o);
  modport slave  (input ex_waddr_reg, ex_we_reg, ex_wdata, output mem_waddr_reg, mem_we_reg, mem_wdata, mem_valid_o);
endinterface

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register with stall/flush handling, r0 write squash and a sticky hold timeout
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int STALL_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall,
  input  logic       flush,
  ex_mem_if.slave    bus,
  output logic       stall_timeout_o
);
  mem_entry_t ent_q, ent_d;
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d, hold, cap;
  logic       unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};
  always_comb begin
    // MEM stalled holds whether or not EX is stalled; EX running with MEM stalled is illegal but holds too
    hold  = !flush && stall[StallMem] == Stop;
    cap   = !flush && stall[StallEx] == NoStop && stall[StallMem] == NoStop;
    ent_d = hold ? ent_q
          : cap  ? mem_entry_t'{waddr: bus.ex_waddr_reg, we: bus.ex_we_reg && bus.ex_waddr_reg != '0,
                                wdata: bus.ex_wdata, valid: 1'b1}
          : Bubble;
    cnt_d = !hold ? 8'd0 : cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
    to_d  = to_q || (hold && int'(cnt_d) >= STALL_LIMIT);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q <= Bubble;
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
  assign bus.mem_waddr_reg = ent_q.waddr;
  assign bus.mem_we_reg    = ent_q.we;
  assign bus.mem_wdata     = ent_q.wdata;
  assign bus.mem_valid_o   = ent_q.valid;
  assign stall_timeout_o   = to_q;
endmodule
